mul8_seq: RTL and testbench

- Sequential 8x8 unsigned shift-add multiplier. It produces a 16-bit product in 8 iteration cycles.
- Sits downstream of the gate-level ALU datapath and reuses the 8-bit ripple adder for every partial-product add.
- Provides a start/busy/done handshake so a controller can issue operands and collect the product.

---
 rtl/mul8_seq_pkg.sv | 15 +
 rtl/adder8b.sv | 21 ++
 rtl/and8b.sv | 10 +
 rtl/mul8_dp.sv | 52 +++++
 rtl/mul8_seq.sv | 75 +++++++
 tb/tb_mul8_seq.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mul8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MUL_ITER = 8;
    localparam int PW       = 16;

    localparam logic [2:0] CNT_LAST = 3'(MUL_ITER - 1);

endpackage

// File: rtl/adder8b.sv
// 8-bit gate-level ripple-carry adder.
module adder8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[8];

endmodule

// File: rtl/and8b.sv
// 8-bit bitwise AND gate array.
module and8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    assign y = a & b;

endmodule

// File: rtl/mul8_dp.sv
// Multiplier datapath: M/ACC/Q registers with one add-and-shift per step.
module mul8_dp
    import mul8_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [7:0]    A,
    input  logic [7:0]    B,
    output logic [PW-1:0] P
);

    logic [7:0] m;
    logic [7:0] acc;
    logic [7:0] q;
    logic [7:0] addend;
    logic [7:0] sum;
    logic       c;

    and8b u_gate (
        .a (m),
        .b ({8{q[0]}}),
        .y (addend)
    );

    adder8b u_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (c)
    );

    // carry becomes ACC[7] after the right shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
        end else if (load) begin
            m   <= A;
            acc <= '0;
            q   <= B;
        end else if (step) begin
            {acc, q} <= {c, sum, q[7:1]};
        end
    end

    assign P = {acc, q};

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with start/busy/done handshake.
module mul8_seq
    import mul8_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    A,
    input  logic [7:0]    B,
    output logic [PW-1:0] P,
    output logic          busy,
    output logic          done
);

    state_t     state;
    state_t     nxt;
    logic [2:0] cnt;
    logic       load;
    logic       step;
    logic       last;

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                load = start;
            end
            default: ;
        endcase
    end

    // wraps 7->0 exactly on the RUN-to-DONE edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt + 3'd1;
    end

    mul8_dp u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .A    (A),
        .B    (B),
        .P    (P)
    );

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: directed operands, monitor checks each done.
module tb_mul8_seq;

    typedef struct {
        logic [15:0] p;
        int          edge_k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    mul8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            busy_cnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("product", int'(P), int'(e.p));
                check("latency", cyc - e.edge_k, 8);
                check("busy_cycles", busy_cnt, 8);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        e.p = p;
        e.edge_k = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy || done) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_P", int'(P), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // 1: basic product, then hold in IDLE
        issue(8'd13, 8'd11, 16'h008F);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_P", int'(P), 16'h008F);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);

        // 2: carry-out into ACC[7], and power-of-two case
        issue(8'hFF, 8'hFF, 16'hFE01);
        wait_idle();
        issue(8'h80, 8'h02, 16'h0100);
        wait_idle();

        // 3: zero multiplicand, full latency
        issue(8'h00, 8'h5A, 16'h0000);
        wait_idle();
        issue(8'h5A, 8'h00, 16'h0000);
        wait_idle();

        // 4: start held high, back-to-back
        @(negedge clk);
        A = 8'd3;
        B = 8'd5;
        start = 1'b1;
        e.p = 16'h000F;
        e.edge_k = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        A = 8'h11;
        B = 8'h22;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held_done_seen", int'(done), 1);
        A = 8'd200;
        B = 8'd2;
        e.p = 16'h0190;
        e.edge_k = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("held_no_idle_busy", int'(busy), 1);
        wait_idle();

        // 5: start during RUN is ignored
        issue(8'd7, 8'd9, 16'h003F);
        repeat (3) @(negedge clk);
        A = 8'hFF;
        B = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignore_P", int'(P), 16'h003F);

        // 6: async reset mid-operation
        issue(8'hAA, 8'h55, 16'h3872);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_P", int'(P), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("no_done_after_rst", int'(done), 0);
        check("rst_P_held", int'(P), 0);
        issue(8'hAA, 8'h55, 16'h3872);
        wait_idle();
        check("post_rst_P", int'(P), 16'h3872);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
